// File: rtl/instr_dispatch.sv
// Instruction dispatcher: buffers instruction words in a small FIFO, decodes one
// at a time and drives fetch requests, compute config, vector-reg controls and halt.
module instr_dispatch #(
  parameter int unsigned INSTR_W    = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned N_CH       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic [N_CH-1:0]    fetch_valid,
  input  logic [N_CH-1:0]    fetch_ready,
  input  logic [N_CH-1:0]    fetch_done,
  output logic [15:0]        fetch_src,
  output logic [7:0]         fetch_dst,
  output logic [7:0]         fetch_cnt,
  output logic [7:0]         fetch_mode,
  output logic               cfg_valid,
  output logic [3:0]         kernel_size,
  output logic [7:0]         feature_size,
  output logic               lb_enable,
  output logic               lb_mode,
  output logic               feat_in_sel,
  output logic               feat_out_sel,
  output logic               reg_enable,
  output logic               vreg_sel,
  output logic               exe_done,
  output logic               illegal_op,
  output logic [N_CH-1:0]    pending
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_EXEC     = 2'd1;
  localparam logic [1:0] S_WAIT_BAR = 2'd2;
  localparam logic [1:0] S_HALT     = 2'd3;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_FETCH1 = 8'h01;
  localparam logic [7:0] OP_FETCH2 = 8'h02;
  localparam logic [7:0] OP_FETCH4 = 8'h04;
  localparam logic [7:0] OP_VREG   = 8'h40;
  localparam logic [7:0] OP_BAR    = 8'h44;
  localparam logic [7:0] OP_CFG    = 8'h81;
  localparam logic [7:0] OP_HALT   = 8'h82;

  logic [INSTR_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               instr_ready_q, instr_ready_d;
  logic [1:0]         state_q, state_d;
  logic [INSTR_W-1:0] dec_q, dec_d;
  logic [N_CH-1:0]    pending_q, pending_d, pend_set;
  logic [N_CH-1:0]    fetch_valid_q, fetch_valid_d;
  logic [15:0]        fetch_src_q, fetch_src_d;
  logic [7:0]         fetch_dst_q, fetch_dst_d;
  logic [7:0]         fetch_cnt_q, fetch_cnt_d;
  logic [7:0]         fetch_mode_q, fetch_mode_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic [3:0]         kernel_size_q, kernel_size_d;
  logic [7:0]         feature_size_q, feature_size_d;
  logic               lb_enable_q, lb_enable_d;
  logic               lb_mode_q, lb_mode_d;
  logic               feat_in_sel_q, feat_in_sel_d;
  logic               feat_out_sel_q, feat_out_sel_d;
  logic               reg_enable_q, reg_enable_d;
  logic               vreg_sel_q, vreg_sel_d;
  logic               exe_done_q, exe_done_d;
  logic               illegal_op_q, illegal_op_d;

  logic               push, pop;
  logic [7:0]         fld [8];
  logic [CH_W-1:0]    ch;
  logic [N_CH-1:0]    ch_oh;
  logic               unused_fld;

  // Byte k of the decoded instruction, counted from the MSB end.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      fld[k] = dec_q[INSTR_W-1-8*k -: 8];
    end
  end

  assign ch         = (N_CH > 1) ? fld[1][CH_W-1:0] : '0;
  assign ch_oh      = N_CH'(1) << ch;
  assign unused_fld = ^{fld[4][7:4], fld[5][7:4], fld[6][7:1]};

  assign push = instr_valid && instr_ready_q;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  // FIFO bookkeeping; ready is derived from the next count so it is a flop output.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    instr_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  // Dispatch FSM and registered output next-values.
  always_comb begin
    state_d        = state_q;
    dec_d          = dec_q;
    pend_set       = '0;
    fetch_valid_d  = '0;
    fetch_src_d    = fetch_src_q;
    fetch_dst_d    = fetch_dst_q;
    fetch_cnt_d    = fetch_cnt_q;
    fetch_mode_d   = fetch_mode_q;
    cfg_valid_d    = 1'b0;
    kernel_size_d  = kernel_size_q;
    feature_size_d = feature_size_q;
    lb_enable_d    = lb_enable_q;
    lb_mode_d      = lb_mode_q;
    feat_in_sel_d  = feat_in_sel_q;
    feat_out_sel_d = feat_out_sel_q;
    reg_enable_d   = reg_enable_q;
    vreg_sel_d     = vreg_sel_q;
    exe_done_d     = exe_done_q;
    illegal_op_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          dec_d   = mem_q[rd_ptr_q];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (fld[0])
          OP_FETCH1, OP_FETCH2, OP_FETCH4: begin
            if (fetch_valid_q[ch] && fetch_ready[ch]) begin
              pend_set = ch_oh;
              state_d  = S_IDLE;
            end else if (!pending_q[ch]) begin
              fetch_valid_d = ch_oh;
              fetch_mode_d  = fld[1];
              fetch_src_d   = {fld[2], fld[3]};
              fetch_dst_d   = {fld[4][3:0], fld[5][3:0]};
              fetch_cnt_d   = (fld[0] == OP_FETCH2) ? fld[7] : 8'h00;
            end
          end
          OP_CFG: begin
            cfg_valid_d    = 1'b1;
            kernel_size_d  = fld[3][3:0];
            feature_size_d = fld[2];
            lb_enable_d    = fld[4][0];
            lb_mode_d      = fld[1][0];
            feat_in_sel_d  = fld[6][0];
            feat_out_sel_d = fld[7][0];
            state_d        = S_IDLE;
          end
          OP_VREG: begin
            reg_enable_d = fld[1][0];
            vreg_sel_d   = fld[2][0];
            state_d      = S_IDLE;
          end
          OP_BAR: state_d = S_WAIT_BAR;
          OP_HALT: begin
            if (pending_q == '0) begin
              exe_done_d = 1'b1;
              state_d    = S_HALT;
            end
          end
          OP_NOP: state_d = S_IDLE;
          default: begin
            illegal_op_d = 1'b1;
            state_d      = S_IDLE;
          end
        endcase
      end
      S_WAIT_BAR: begin
        if (pending_q == '0) state_d = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // A set on the same cycle as a completion wins.
    pending_d = (pending_q & ~fetch_done) | pend_set;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= instruction;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      instr_ready_q  <= 1'b1;
      state_q        <= S_IDLE;
      dec_q          <= '0;
      pending_q      <= '0;
      fetch_valid_q  <= '0;
      fetch_src_q    <= '0;
      fetch_dst_q    <= '0;
      fetch_cnt_q    <= '0;
      fetch_mode_q   <= '0;
      cfg_valid_q    <= 1'b0;
      kernel_size_q  <= '0;
      feature_size_q <= '0;
      lb_enable_q    <= 1'b0;
      lb_mode_q      <= 1'b0;
      feat_in_sel_q  <= 1'b0;
      feat_out_sel_q <= 1'b0;
      reg_enable_q   <= 1'b0;
      vreg_sel_q     <= 1'b0;
      exe_done_q     <= 1'b0;
      illegal_op_q   <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      instr_ready_q  <= instr_ready_d;
      state_q        <= state_d;
      dec_q          <= dec_d;
      pending_q      <= pending_d;
      fetch_valid_q  <= fetch_valid_d;
      fetch_src_q    <= fetch_src_d;
      fetch_dst_q    <= fetch_dst_d;
      fetch_cnt_q    <= fetch_cnt_d;
      fetch_mode_q   <= fetch_mode_d;
      cfg_valid_q    <= cfg_valid_d;
      kernel_size_q  <= kernel_size_d;
      feature_size_q <= feature_size_d;
      lb_enable_q    <= lb_enable_d;
      lb_mode_q      <= lb_mode_d;
      feat_in_sel_q  <= feat_in_sel_d;
      feat_out_sel_q <= feat_out_sel_d;
      reg_enable_q   <= reg_enable_d;
      vreg_sel_q     <= vreg_sel_d;
      exe_done_q     <= exe_done_d;
      illegal_op_q   <= illegal_op_d;
    end
  end

  assign instr_ready  = instr_ready_q;
  assign fetch_valid  = fetch_valid_q;
  assign fetch_src    = fetch_src_q;
  assign fetch_dst    = fetch_dst_q;
  assign fetch_cnt    = fetch_cnt_q;
  assign fetch_mode   = fetch_mode_q;
  assign cfg_valid    = cfg_valid_q;
  assign kernel_size  = kernel_size_q;
  assign feature_size = feature_size_q;
  assign lb_enable    = lb_enable_q;
  assign lb_mode      = lb_mode_q;
  assign feat_in_sel  = feat_in_sel_q;
  assign feat_out_sel = feat_out_sel_q;
  assign reg_enable   = reg_enable_q;
  assign vreg_sel     = vreg_sel_q;
  assign exe_done     = exe_done_q;
  assign illegal_op   = illegal_op_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Bench for instr_dispatch: directed scenarios plus a random instruction stream
// checked against a transaction-level model of fetches, configs and illegal ops.
module tb_instr_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [63:0] instruction;
  logic [3:0]  fetch_valid, fetch_ready, fetch_done, pending;
  logic [15:0] fetch_src;
  logic [7:0]  fetch_dst, fetch_cnt, fetch_mode, feature_size;
  logic [3:0]  kernel_size;
  logic        cfg_valid, lb_enable, lb_mode, feat_in_sel, feat_out_sel;
  logic        reg_enable, vreg_sel, exe_done, illegal_op;

  always #5 clk = ~clk;

  instr_dispatch #(.INSTR_W(64), .FIFO_DEPTH(4), .N_CH(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_done(fetch_done),
    .fetch_src(fetch_src), .fetch_dst(fetch_dst), .fetch_cnt(fetch_cnt), .fetch_mode(fetch_mode),
    .cfg_valid(cfg_valid), .kernel_size(kernel_size), .feature_size(feature_size),
    .lb_enable(lb_enable), .lb_mode(lb_mode), .feat_in_sel(feat_in_sel), .feat_out_sel(feat_out_sel),
    .reg_enable(reg_enable), .vreg_sel(vreg_sel), .exe_done(exe_done),
    .illegal_op(illegal_op), .pending(pending)
  );

  typedef struct packed {
    logic [3:0]  ch;
    logic [7:0]  mode;
    logic [15:0] src;
    logic [7:0]  dst;
    logic [7:0]  cnt;
  } fetch_t;

  typedef struct packed {
    logic [3:0] ks;
    logic [7:0] fs;
    logic       lbe;
    logic       lbm;
    logic       fi;
    logic       fo;
  } cfg_t;

  fetch_t     exp_fetch[$];
  cfg_t       exp_cfg[$];
  int         exp_illegal;
  logic [1:0] exp_reg;
  logic [3:0] mp;
  bit         auto_resp;
  int         n_checks;
  int         n_errors;

  function automatic logic [7:0] fb(input logic [63:0] w, input int k);
    return 8'(w >> (56 - 8 * k));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // What an accepted instruction must eventually produce.
  task automatic model_accept(input logic [63:0] w);
    fetch_t f;
    cfg_t   c;
    logic [7:0] op;
    op = fb(w, 0);
    case (op)
      8'h01, 8'h02, 8'h04: begin
        f.ch   = 4'(1 << (fb(w, 1) % 4));
        f.mode = fb(w, 1);
        f.src  = 16'(fb(w, 2) * 256 + fb(w, 3));
        f.dst  = 8'((fb(w, 4) % 16) * 16 + fb(w, 5) % 16);
        f.cnt  = (op == 8'h02) ? fb(w, 7) : 8'h00;
        exp_fetch.push_back(f);
      end
      8'h81: begin
        c.ks  = 4'(fb(w, 3) % 16);
        c.fs  = fb(w, 2);
        c.lbe = 1'(fb(w, 4) % 2);
        c.lbm = 1'(fb(w, 1) % 2);
        c.fi  = 1'(fb(w, 6) % 2);
        c.fo  = 1'(fb(w, 7) % 2);
        exp_cfg.push_back(c);
      end
      8'h40: exp_reg = {1'(fb(w, 1) % 2), 1'(fb(w, 2) % 2)};
      8'h00, 8'h44, 8'h82: ;
      default: exp_illegal++;
    endcase
  endtask

  // One clock: optional random responder, edge, then monitor checks.
  task automatic tick();
    logic [3:0]  hs, done, pfv;
    logic [39:0] pflds;
    logic        pushed, was_rst;
    logic [63:0] pw;
    fetch_t      f;
    cfg_t        c;
    if (auto_resp) begin
      fetch_ready = 4'($urandom);
      fetch_done  = 4'($urandom & $urandom);
    end
    hs      = fetch_valid & fetch_ready;
    done    = fetch_done;
    pushed  = instr_valid & instr_ready;
    pw      = instruction;
    was_rst = rst;
    pfv     = fetch_valid;
    pflds   = {fetch_src, fetch_dst, fetch_cnt, fetch_mode};
    if (!was_rst && hs != 4'b0) begin
      if (exp_fetch.size() == 0) begin
        chk("fetch_unexpected", 64'(hs), 64'(0));
      end else begin
        f = exp_fetch.pop_front();
        chk("fetch_ch", 64'(fetch_valid), 64'(f.ch));
        chk("fetch_fields", {fetch_src, fetch_dst, fetch_cnt, fetch_mode},
            {f.src, f.dst, f.cnt, f.mode});
      end
    end
    @(posedge clk);
    #1;
    if (was_rst) begin
      mp = 4'b0;
      exp_fetch.delete();
      exp_cfg.delete();
      exp_illegal = 0;
      exp_reg = 2'b00;
    end else begin
      mp = (mp & ~done) | hs;
      if (pushed) model_accept(pw);
      chk("pending", 64'(pending), 64'(mp));
      chk("fv_on_pending", 64'(fetch_valid & pending), 64'(0));
      if (pfv != 4'b0 && hs == 4'b0)
        chk("fetch_hold", {fetch_valid, fetch_src, fetch_dst, fetch_cnt, fetch_mode}, {pfv, pflds});
      if (cfg_valid) begin
        if (exp_cfg.size() == 0) begin
          chk("cfg_unexpected", 64'(cfg_valid), 64'(0));
        end else begin
          c = exp_cfg.pop_front();
          chk("cfg_fields", {kernel_size, feature_size, lb_enable, lb_mode, feat_in_sel, feat_out_sel},
              64'(c));
        end
      end
      if (illegal_op) begin
        chk("illegal_expected", 64'(exp_illegal > 0), 64'(1));
        if (exp_illegal > 0) exp_illegal--;
      end
    end
  endtask

  task automatic push_instr(input logic [63:0] w);
    bit acc;
    acc = 1'b0;
    instr_valid = 1'b1;
    instruction = w;
    for (int i = 0; i < 500 && !acc; i++) begin
      acc = instr_ready;
      tick();
    end
    instr_valid = 1'b0;
    chk("push_accepted", 64'(acc), 64'(1));
  endtask

  task automatic drain();
    auto_resp = 1'b1;
    for (int i = 0; i < 3000 && (exp_fetch.size() + exp_cfg.size() + exp_illegal) != 0; i++) tick();
    chk("drain_empty", 64'(exp_fetch.size() + exp_cfg.size() + exp_illegal), 64'(0));
    repeat (20) tick();
    auto_resp = 1'b0;
    fetch_ready = 4'b0;
    fetch_done = 4'hF;
    tick();
    tick();
    fetch_done = 4'b0;
    repeat (10) tick();
    chk("drain_pending", 64'(pending), 64'(0));
    chk("reg_state", 64'({reg_enable, vreg_sel}), 64'(exp_reg));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_ready", 64'(instr_ready), 64'(1));
    chk("rst_fetch", {fetch_valid, fetch_src, fetch_dst, fetch_cnt, fetch_mode}, 64'(0));
    chk("rst_cfg", {cfg_valid, kernel_size, feature_size, lb_enable, lb_mode, feat_in_sel, feat_out_sel},
        64'(0));
    chk("rst_misc", 64'({reg_enable, vreg_sel, exe_done, illegal_op, pending}), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op;
    n_checks = 0; n_errors = 0;
    rst = 1'b1; instr_valid = 1'b0; instruction = 64'b0;
    fetch_ready = 4'b0; fetch_done = 4'b0; auto_resp = 1'b0;
    mp = 4'b0; exp_illegal = 0; exp_reg = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_state();

    // Fetch latency, field mapping, hold and pending set/clear
    push_instr(64'h0201_1234_0506_0010);
    tick();
    chk("lat_n1_fv", 64'(fetch_valid), 64'(0));
    tick();
    chk("lat_fv", 64'(fetch_valid), 64'(4'b0010));
    chk("lat_fields", {fetch_src, fetch_dst, fetch_cnt, fetch_mode}, 64'h1234_56_10_01);
    repeat (3) begin
      tick();
      chk("hold_fv", 64'(fetch_valid), 64'(4'b0010));
    end
    fetch_ready = 4'b0010;
    tick();
    fetch_ready = 4'b0;
    chk("pend1", 64'(pending), 64'(4'b0010));
    chk("fv_drop", 64'(fetch_valid), 64'(0));
    fetch_done = 4'b1010;
    tick();
    fetch_done = 4'b0;
    chk("pend_clr", 64'(pending), 64'(0));

    // Back-to-back fetches to channel 0 with completion withheld
    fetch_ready = 4'b0001;
    push_instr(64'h0100_AAAA_0102_0000);
    push_instr(64'h0400_BBBB_0304_0000);
    for (int i = 0; i < 20 && pending[0] !== 1'b1; i++) tick();
    chk("ch0_pending", 64'(pending[0]), 64'(1));
    repeat (5) begin
      tick();
      chk("stall_fv", 64'(fetch_valid), 64'(0));
    end
    fetch_done = 4'b0001;
    tick();
    fetch_done = 4'b0;
    for (int i = 0; i < 2 && fetch_valid !== 4'b0001; i++) tick();
    chk("release_fv", 64'(fetch_valid), 64'(4'b0001));
    chk("release_src", 64'(fetch_src), 64'(16'hBBBB));
    tick();
    fetch_ready = 4'b0;
    chk("release_pend", 64'(pending), 64'(4'b0001));
    fetch_done = 4'b0001;
    tick();
    fetch_done = 4'b0;

    // FIFO fill while the FSM is stalled on an unaccepted fetch
    push_instr(64'h0102_0000_0000_0000);
    tick();
    tick();
    chk("stall_fetch_fv", 64'(fetch_valid), 64'(4'b0100));
    push_instr(64'h8100_1105_0100_0001);
    push_instr(64'h0103_5566_0708_0000);
    push_instr(64'h8101_2209_0000_0100);
    push_instr(64'h0200_7788_0A0B_00F3);
    chk("full_ready", 64'(instr_ready), 64'(0));
    instr_valid = 1'b1;
    instruction = 64'h0101_99AA_0C0D_0000;
    repeat (3) begin
      tick();
      chk("full_hold", 64'(instr_ready), 64'(0));
    end
    auto_resp = 1'b1;
    push_instr(64'h0101_99AA_0C0D_0000);
    drain();

    // Barrier waits for two outstanding fetches, then config follows
    fetch_ready = 4'hF;
    push_instr(64'h0100_1000_0000_0000);
    push_instr(64'h0102_2000_0000_0000);
    push_instr(64'h4400_0000_0000_0000);
    push_instr(64'h8101_2003_0100_0100);
    for (int i = 0; i < 30 && pending !== 4'b0101; i++) tick();
    chk("bar_pending", 64'(pending), 64'(4'b0101));
    fetch_ready = 4'b0;
    repeat (6) begin
      tick();
      chk("bar_wait_cfg", 64'(cfg_valid), 64'(0));
    end
    fetch_done = 4'b0001;
    tick();
    fetch_done = 4'b0;
    repeat (3) begin
      tick();
      chk("bar_wait_cfg2", 64'(cfg_valid), 64'(0));
    end
    fetch_done = 4'b0100;
    tick();
    fetch_done = 4'b0;
    for (int i = 0; i < 8 && cfg_valid !== 1'b1; i++) tick();
    chk("bar_cfg", 64'(cfg_valid), 64'(1));
    chk("bar_kernel", 64'(kernel_size), 64'(3));
    chk("bar_cfg_rest", 64'({feature_size, lb_enable, lb_mode, feat_in_sel, feat_out_sel}),
        64'({8'h20, 4'b1110}));
    tick();
    chk("cfg_one_cycle", 64'(cfg_valid), 64'(0));

    // Random stream against the model
    auto_resp = 1'b1;
    repeat (60) begin
      case ($urandom_range(0, 7))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h04;
        3: op = 8'h81;
        4: op = 8'h40;
        5: op = 8'h44;
        6: op = 8'h00;
        default: op = 8'h10 + 8'($urandom_range(0, 15));
      endcase
      push_instr({op, 32'($urandom), 24'($urandom)});
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();

    // Reset in the middle of a fetch discards it and the queue
    push_instr(64'h0103_1111_0000_0000);
    push_instr(64'h8100_0101_0000_0000);
    push_instr(64'h0101_2222_0000_0000);
    for (int i = 0; i < 20 && fetch_valid !== 4'b1000; i++) tick();
    chk("mid_fv", 64'(fetch_valid), 64'(4'b1000));
    do_reset();
    chk("mid_rst_fv", 64'(fetch_valid), 64'(0));
    chk("mid_rst_ready", 64'(instr_ready), 64'(1));
    repeat (6) begin
      tick();
      chk("mid_rst_quiet", 64'({fetch_valid, cfg_valid}), 64'(0));
    end

    // Illegal opcode then halt; halted FSM stops popping
    push_instr(64'h7F00_0000_0000_0000);
    push_instr(64'h8200_0000_0000_0000);
    for (int i = 0; i < 10 && illegal_op !== 1'b1; i++) tick();
    chk("illegal_pulse", 64'(illegal_op), 64'(1));
    tick();
    chk("illegal_one_cycle", 64'(illegal_op), 64'(0));
    for (int i = 0; i < 10 && exe_done !== 1'b1; i++) tick();
    chk("exe_done", 64'(exe_done), 64'(1));
    repeat (4) push_instr(64'h8100_0102_0000_0000);
    chk("halt_full", 64'(instr_ready), 64'(0));
    repeat (8) begin
      tick();
      chk("halt_no_pop", 64'({cfg_valid, exe_done}), 64'(1));
    end
    do_reset();
    chk_reset_state();
    repeat (5) begin
      tick();
      chk("post_rst_quiet", 64'({cfg_valid, exe_done}), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
